// File: rtl/tristate_bus_ctrl.sv
// Round-robin owner arbitration for a shared tristate bus, with bounded hold
// time under contention, a fixed turnaround gap and sampling of the idle bus.
module tristate_bus_ctrl #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int TURNAROUND = 2,
  parameter int MAX_HOLD   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] wdata,
  output logic [CHANNELS-1:0]       gnt,
  inout  wire  [WIDTH-1:0]          bus,
  output logic                      bus_oe,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rvalid
);

  localparam int OW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t              state;
  logic [OW-1:0]       owner;
  logic [OW-1:0]       last_owner;
  logic [OW-1:0]       next_sel;
  logic [CHANNELS-1:0] sel_onehot;
  logic [7:0]          hold_cnt;
  logic [3:0]          turn_cnt;
  logic                others_req;
  logic [WIDTH-1:0]    wdata_ch [CHANNELS];

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      wdata_ch[k] = wdata[k*WIDTH +: WIDTH];
    end
  end

  // Scan downward so the channel closest after last_owner is the final winner.
  always_comb begin
    next_sel = last_owner;
    for (int i = CHANNELS; i >= 1; i--) begin
      if (req[OW'((int'(last_owner) + i) % CHANNELS)]) begin
        next_sel = OW'((int'(last_owner) + i) % CHANNELS);
      end
    end
  end

  assign sel_onehot = {{(CHANNELS-1){1'b0}}, 1'b1} << next_sel;
  assign others_req = |(req & ~gnt);

  assign bus = bus_oe ? wdata_ch[owner] : {WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      bus_oe     <= 1'b0;
      owner      <= '0;
      last_owner <= OW'(CHANNELS - 1);
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdata  <= bus;
          rvalid <= 1'b1;
          if (|req) begin
            state      <= DRIVE;
            gnt        <= sel_onehot;
            bus_oe     <= 1'b1;
            owner      <= next_sel;
            last_owner <= next_sel;
            hold_cnt   <= 8'd1;
          end
        end
        DRIVE: begin
          rvalid <= 1'b0;
          // Release and preemption both land in the same single TURN entry.
          if (!req[owner] || (hold_cnt >= HOLD_MAX && others_req)) begin
            state    <= TURN;
            gnt      <= '0;
            bus_oe   <= 1'b0;
            turn_cnt <= '0;
            hold_cnt <= '0;
          end else if (hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        TURN: begin
          rvalid <= 1'b0;
          if (turn_cnt == TURN_LAST) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          gnt    <= '0;
          bus_oe <= 1'b0;
          rvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Directed checks of tristate_bus_ctrl: grant latency, turnaround, round-robin,
// hold without contention, idle bus capture and asynchronous reset.
module tb_tristate_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  wire  [7:0]  bus;
  logic        bus_oe;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        ext_oe;
  logic [7:0]  ext_data;

  int tests;
  int fails;

  logic [3:0] rr_gnt [5];
  logic [7:0] rr_data [5];

  tristate_bus_ctrl #(
    .WIDTH(8), .CHANNELS(4), .TURNAROUND(2), .MAX_HOLD(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt),
    .bus(bus), .bus_oe(bus_oe), .rdata(rdata), .rvalid(rvalid)
  );

  assign bus = ext_oe ? ext_data : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    wdata    = {8'h44, 8'h33, 8'h22, 8'hA5};
    ext_oe   = 1'b0;
    ext_data = 8'h00;
    rr_gnt   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_data  = '{8'hA5, 8'h22, 8'h33, 8'h44, 8'hA5};

    // Reset state
    tick();
    tick();
    check_output("reset_gnt", 32'(gnt), 32'h0);
    check_output("reset_oe", 32'(bus_oe), 32'h0);
    check_output("reset_rvalid", 32'(rvalid), 32'h0);
    check_output("reset_rdata", 32'(rdata), 32'h0);
    rst_n = 1'b1;

    // Single request: one-cycle grant, then two TURN cycles and IDLE
    apply_stimulus(4'b0001);
    tick();
    check_output("single_gnt", 32'(gnt), 32'h1);
    check_output("single_oe", 32'(bus_oe), 32'h1);
    check_output("single_bus", 32'(bus), 32'hA5);
    check_output("single_rvalid_idle", 32'(rvalid), 32'h1);
    apply_stimulus(4'b0000);
    tick();
    check_output("turn1_gnt", 32'(gnt), 32'h0);
    check_output("turn1_oe", 32'(bus_oe), 32'h0);
    check_output("turn1_rvalid", 32'(rvalid), 32'h0);
    tick();
    check_output("turn2_oe", 32'(bus_oe), 32'h0);
    tick();
    check_output("turn_end_rvalid", 32'(rvalid), 32'h0);
    tick();
    check_output("idle_rvalid", 32'(rvalid), 32'h1);

    // External driver during IDLE is captured
    ext_data = 8'h3C;
    ext_oe   = 1'b1;
    tick();
    check_output("capture_rdata", 32'(rdata), 32'h3C);
    check_output("capture_rvalid", 32'(rvalid), 32'h1);
    check_output("capture_oe", 32'(bus_oe), 32'h0);
    ext_oe = 1'b0;

    // Fresh reset so round-robin starts at channel 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    apply_stimulus(4'b1111);
    tick();
    for (int j = 0; j < 5; j++) begin
      check_output($sformatf("rr%0d_bus", j), 32'(bus), 32'(rr_data[j]));
      for (int c = 0; c < 8; c++) begin
        check_output($sformatf("rr%0d_gnt_c%0d", j, c), 32'(gnt), 32'(rr_gnt[j]));
        tick();
      end
      if (j < 4) begin
        for (int c = 0; c < 3; c++) begin
          check_output($sformatf("rr%0d_gap_c%0d", j, c), 32'(gnt), 32'h0);
          tick();
        end
      end
    end
    check_output("rr_end_turn_oe", 32'(bus_oe), 32'h0);
    apply_stimulus(4'b0000);
    tick();
    tick();
    check_output("rr_idle_gnt", 32'(gnt), 32'h0);

    // Lone requester is never preempted
    apply_stimulus(4'b0100);
    tick();
    check_output("hold_bus", 32'(bus), 32'h33);
    for (int c = 0; c < 20; c++) begin
      check_output($sformatf("hold_gnt_c%0d", c), 32'(gnt), 32'h4);
      tick();
    end

    // Asynchronous reset in the middle of channel 2's DRIVE
    rst_n = 1'b0;
    #1;
    check_output("async_rst_gnt", 32'(gnt), 32'h0);
    check_output("async_rst_oe", 32'(bus_oe), 32'h0);
    apply_stimulus(4'b0101);
    #3;
    rst_n = 1'b1;
    tick();
    check_output("post_rst_gnt", 32'(gnt), 32'h1);
    check_output("post_rst_bus", 32'(bus), 32'hA5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
